psx_host: RTL

- Parametrised PlayStation controller host; next generation of the single-port fake_psx console model.
- Polls NUM_PORTS controllers round-robin over the shared psx_clk/cmd/data/ack bus, with one att line per port.
- Publishes per-port button state, controller ID and a presence flag for the rest of the design.
- Adds a programmable bit rate, ack timeout with no-controller detection, and inter-poll spacing.

---
 rtl/psx_pkg.sv | 34 +++
 rtl/psx_byte_xfer.sv | 98 +++++++++
 rtl/psx_host.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/psx_pkg.sv
// psx_pkg: protocol constants, FSM state types and command-byte lookup shared by
// the PlayStation controller host and its byte shifter.
package psx_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_POLL   = 8'h42;
  localparam logic [7:0] RSP_READY  = 8'h5A;
  localparam logic [7:0] ID_DIGITAL = 8'h41;
  localparam logic [7:0] ID_ANALOG  = 8'h73;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    ACK_WAIT,
    DONE,
    GAP
  } host_state_t;

  typedef enum logic [1:0] {
    BX_IDLE,
    BIT_LO,
    BIT_HI
  } bit_state_t;

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_byte = CMD_START;
      4'd1:    cmd_byte = CMD_POLL;
      default: cmd_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/psx_byte_xfer.sv
// psx_byte_xfer: shifts one byte LSB first on cmd while capturing data; psx_clk is
// low then high for CLK_DIV cycles per bit, data sampled on the last high cycle.
module psx_byte_xfer
  import psx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       data,
  output logic       psx_clk,
  output logic       cmd,
  output logic [7:0] rx,
  output logic       done
);

  bit_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d, rx_d;
  logic        clk_d, cmd_d, done_d;
  logic        half_end;

  assign half_end = (cnt_q == 16'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx;
    clk_d   = psx_clk;
    cmd_d   = cmd;
    done_d  = 1'b0;
    case (state_q)
      BX_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = BIT_LO;
          tx_d    = tx;
          bit_d   = '0;
          clk_d   = 1'b0;
          cmd_d   = tx[0];
        end
      end
      BIT_LO: begin
        if (half_end) begin
          state_d = BIT_HI;
          cnt_d   = '0;
          clk_d   = 1'b1;
        end
      end
      BIT_HI: begin
        if (half_end) begin
          cnt_d = '0;
          rx_d  = {data, rx[7:1]};
          if (bit_q == 3'd7) begin
            // psx_clk stays high and cmd returns to idle between bytes
            state_d = BX_IDLE;
            done_d  = 1'b1;
            cmd_d   = 1'b1;
          end else begin
            state_d = BIT_LO;
            bit_d   = bit_q + 3'd1;
            clk_d   = 1'b0;
            cmd_d   = tx_q[bit_q + 3'd1];
          end
        end
      end
      default: state_d = BX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '1;
      rx      <= '1;
      psx_clk <= 1'b1;
      cmd     <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx      <= rx_d;
      psx_clk <= clk_d;
      cmd     <= cmd_d;
      done    <= done_d;
    end
  end

endmodule

// File: rtl/psx_host.sv
// psx_host: polls NUM_PORTS PlayStation controllers round-robin and publishes per-port
// buttons, ID and presence. Define PSX_ANALOG_EN to add 9-byte analog stick capture.
module psx_host
  import psx_pkg::*;
#(
  parameter  int NUM_PORTS   = 2,
  parameter  int CLK_DIV     = 4,
  parameter  int ACK_TIMEOUT = 64,
  parameter  int ATT_SETUP   = 8,
  parameter  int POLL_GAP    = 256,
  localparam int PW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    poll_en,
  input  logic                    data,
  input  logic                    ack,
  output logic                    psx_clk,
  output logic                    cmd,
  output logic [NUM_PORTS-1:0]    att,
  output logic [16*NUM_PORTS-1:0] buttons,
  output logic [8*NUM_PORTS-1:0]  ctrl_id,
  output logic [NUM_PORTS-1:0]    present,
  output logic                    rsp_valid,
  output logic [PW-1:0]           rsp_port
`ifdef PSX_ANALOG_EN
  ,
  output logic [32*NUM_PORTS-1:0] sticks
`endif
);

  logic        data_meta, data_s, ack_meta, ack_s;
  host_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  byte_q, byte_d, last_byte;
  logic        acked_q, acked_d, aborted_q, aborted_d;
  logic [PW-1:0] port_q, port_d;
  logic        start, bx_done, valid;
  logic [7:0]  bx_rx;
  logic [7:0]  cap_id, cap_rdy, cap_lo, cap_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_s    <= 1'b1;
      ack_meta  <= 1'b1;
      ack_s     <= 1'b1;
    end else begin
      data_meta <= data;
      data_s    <= data_meta;
      ack_meta  <= ack;
      ack_s     <= ack_meta;
    end
  end

  psx_byte_xfer #(.CLK_DIV(CLK_DIV)) u_xfer (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx      (cmd_byte(byte_q)),
    .data    (data_s),
    .psx_clk (psx_clk),
    .cmd     (cmd),
    .rx      (bx_rx),
    .done    (bx_done)
  );

`ifdef PSX_ANALOG_EN
  localparam logic [31:0] STICK_REST = 32'h80808080;
  logic [31:0] cap_stk;
  assign last_byte = (cap_id == ID_ANALOG) ? 4'd8 : 4'd4;
`else
  assign last_byte = 4'd4;
`endif

  // captured bytes may be stale after an abort; aborted_q masks them
  assign valid = !aborted_q && (cap_rdy == RSP_READY);

  always_comb begin
    att = '1;
    if (state_q == SETUP || state_q == XFER || state_q == ACK_WAIT) att[port_q] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    byte_d    = byte_q;
    acked_d   = acked_q;
    aborted_d = aborted_q;
    port_d    = port_q;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (poll_en) begin
          state_d   = SETUP;
          byte_d    = '0;
          acked_d   = 1'b0;
          aborted_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == 16'(ATT_SETUP - 1)) begin
          start   = 1'b1;
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        cnt_d = '0;
        if (bx_done) begin
          acked_d = 1'b0;
          if (byte_q == last_byte) begin
            state_d = DONE;
          end else begin
            state_d = ACK_WAIT;
            byte_d  = byte_q + 4'd1;
          end
        end
      end
      ACK_WAIT: begin
        // ack is checked before the timeout so a coincident ack wins
        if (!acked_q) begin
          if (!ack_s) begin
            acked_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end
        end else if (cnt_q == 16'(CLK_DIV - 1)) begin
          start   = 1'b1;
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: begin
        if (cnt_q == 16'(POLL_GAP - 1)) begin
          state_d = IDLE;
          port_d  = (port_q == PW'(NUM_PORTS - 1)) ? '0 : port_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      byte_q    <= '0;
      acked_q   <= 1'b0;
      aborted_q <= 1'b0;
      port_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      acked_q   <= acked_d;
      aborted_q <= aborted_d;
      port_q    <= port_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_id    <= '1;
      cap_rdy   <= '1;
      cap_lo    <= '1;
      cap_hi    <= '1;
      buttons   <= '1;
      ctrl_id   <= '1;
      present   <= '0;
      rsp_valid <= 1'b0;
      rsp_port  <= '0;
`ifdef PSX_ANALOG_EN
      cap_stk   <= STICK_REST;
      sticks    <= {NUM_PORTS{STICK_REST}};
`endif
    end else begin
      rsp_valid <= (state_q == DONE);
      if (state_q == XFER && bx_done) begin
        case (byte_q)
          4'd1: cap_id  <= bx_rx;
          4'd2: cap_rdy <= bx_rx;
          4'd3: cap_lo  <= bx_rx;
          4'd4: cap_hi  <= bx_rx;
`ifdef PSX_ANALOG_EN
          4'd5: cap_stk[7:0]   <= bx_rx;
          4'd6: cap_stk[15:8]  <= bx_rx;
          4'd7: cap_stk[23:16] <= bx_rx;
          4'd8: cap_stk[31:24] <= bx_rx;
`endif
          default: ;
        endcase
      end
      if (state_q == DONE) begin
        rsp_port                        <= port_q;
        present[port_q]                 <= valid;
        buttons[16*int'(port_q) +: 16]  <= valid ? {cap_hi, cap_lo} : 16'hFFFF;
        ctrl_id[8*int'(port_q) +: 8]    <= valid ? cap_id : 8'hFF;
`ifdef PSX_ANALOG_EN
        sticks[32*int'(port_q) +: 32]   <= (valid && cap_id == ID_ANALOG) ? cap_stk : STICK_REST;
`endif
      end
    end
  end

endmodule
